// File: rtl/data_memory_be.sv
`default_nettype none
// ----------------------------------------------------------------------------
// data_memory_be : 32-bit word memory with RISC-V byte/half/word access and
//                  configurable load latency.          Rev 1.0
// ----------------------------------------------------------------------------
module data_memory_be #(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         DEPTH    = 2 ** ADDR_W;
  localparam logic [1:0] CNT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic              accept;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       word;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic              is_byte, is_half, is_word, sext;
  logic              fault;
  logic [31:0]       load_val;
  logic [3:0]        be;
  logic [31:0]       wdata_lanes;
  logic              mem_we;

  assign req_ready = (state_q == S_IDLE) && !reset;
  assign rsp_valid = (state_q == S_RESP) && !reset;
  assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
  assign rsp_err   = rsp_valid && err_q;

  assign accept   = req_valid && req_ready;
  assign idx      = req_addr[ADDR_W+1:2];
  assign word     = mem[idx];
  assign byte_sel = word[{req_addr[1:0], 3'b000} +: 8];
  assign half_sel = word[{req_addr[1], 4'b0000} +: 16];

  // Access decode: size, signedness and every fault condition.
  always_comb begin
    is_byte = 1'b0;
    is_half = 1'b0;
    is_word = 1'b0;
    sext    = 1'b0;
    case (req_funct3)
      3'b000: begin is_byte = 1'b1; sext = 1'b1; end
      3'b001: begin is_half = 1'b1; sext = 1'b1; end
      3'b010: is_word = 1'b1;
      3'b100: is_byte = !req_we;
      3'b101: is_half = !req_we;
      default: ;
    endcase
    fault = !(is_byte || is_half || is_word)
          || (is_half && req_addr[0])
          || (is_word && (req_addr[1:0] != 2'b00))
          || ((req_addr >> (ADDR_W + 2)) != 32'd0);
  end

  always_comb begin
    load_val    = word;
    be          = 4'b1111;
    wdata_lanes = req_wdata;
    if (is_byte) begin
      load_val    = {{24{sext && byte_sel[7]}}, byte_sel};
      be          = 4'b0001 << req_addr[1:0];
      wdata_lanes = {4{req_wdata[7:0]}};
    end else if (is_half) begin
      load_val    = {{16{sext && half_sel[15]}}, half_sel};
      be          = req_addr[1] ? 4'b1100 : 4'b0011;
      wdata_lanes = {2{req_wdata[15:0]}};
    end
  end

  assign mem_we = accept && req_we && !fault;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          err_d   = fault;
          rdata_d = (req_we || fault) ? 32'd0 : load_val;
          // Good loads with extra latency park in BUSY; everything else answers next cycle.
          if (!req_we && !fault && (RD_LAT > 1)) begin
            state_d = S_BUSY;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == 2'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 2'd1;
      end
      S_RESP: begin
        state_d = S_IDLE;
        rdata_d = 32'd0;
        err_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage survives reset; writes are already blocked by req_ready during reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_be.sv
`default_nettype none
// Bench for data_memory_be: three instances (RD_LAT 1, 3, 4) share stimulus and
// are checked against a byte-addressed reference memory.
module tb_data_memory_be;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [NI-1:0] rdy, rv, er;
  logic [31:0]   rd [NI];

  int total = 0;
  int bad   = 0;

  logic [7:0] mb [1024];

  always #5 clk = ~clk;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    data_memory_be #(
      .ADDR_W(8),
      .RD_LAT((g == 0) ? 1 : ((g == 1) ? 3 : 4))
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (rdy[g]),
      .req_we    (req_we),
      .req_funct3(req_funct3),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rv[g]),
      .rsp_rdata (rd[g]),
      .rsp_err   (er[g])
    );
  end

  // Reference: byte-addressed memory, 1 KiB, little-endian.
  function automatic void model(input logic we, input logic [2:0] f, input logic [31:0] a,
                                input logic [31:0] wd, output logic e,
                                output logic [31:0] r, output logic ld);
    int n;
    bit sg, ok;
    n = 1; sg = 0; ok = 1;
    case (f)
      3'd0: begin n = 1; sg = 1; end
      3'd1: begin n = 2; sg = 1; end
      3'd2: n = 4;
      3'd4: begin n = 1; ok = !we; end
      3'd5: begin n = 2; ok = !we; end
      default: ok = 0;
    endcase
    e  = !ok || ((a % n) != 0) || (a >= 32'd1024);
    r  = 32'd0;
    ld = !we && !e;
    if (!e) begin
      if (we) begin
        for (int i = 0; i < n; i++) mb[a + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) r[8*i +: 8] = mb[a + i];
        if (sg && n < 4 && r[8*n-1])
          for (int i = n; i < 4; i++) r[8*i +: 8] = 8'hFF;
      end
    end
  endfunction

  task automatic do_req(input logic we, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] wd);
    logic e, ld, want_rdy;
    logic [31:0] r;
    int exp_lat;
    model(we, f, a, wd, e, r, ld);
    for (int g = 0; g < NI; g++) begin
      total++;
      if (rdy[g] !== 1'b1) begin
        bad++;
        $display("FAIL ready_idle inst=%0d got=%b want=1", g, rdy[g]);
      end
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = $urandom;
    for (int n = 1; n <= 6; n++) begin
      for (int g = 0; g < NI; g++) begin
        exp_lat = ld ? lat_of(g) : 1;
        total++;
        if (n == exp_lat) begin
          if (rv[g] !== 1'b1 || rd[g] !== r || er[g] !== e || rdy[g] !== 1'b0) begin
            bad++;
            $display("FAIL rsp inst=%0d we=%b f3=%0d addr=%h cyc=%0d got v=%b d=%h e=%b rdy=%b want v=1 d=%h e=%b rdy=0",
                     g, we, f, a, n, rv[g], rd[g], er[g], rdy[g], r, e);
          end
        end else begin
          want_rdy = (n > exp_lat);
          if (rv[g] !== 1'b0 || rd[g] !== 32'd0 || er[g] !== 1'b0 || rdy[g] !== want_rdy) begin
            bad++;
            $display("FAIL quiet inst=%0d addr=%h cyc=%0d got v=%b d=%h e=%b rdy=%b want v=0 d=0 e=0 rdy=%b",
                     g, a, n, rv[g], rd[g], er[g], rdy[g], want_rdy);
          end
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_quiet(input string tag, input logic want_rdy);
    for (int g = 0; g < NI; g++) begin
      total++;
      if (rv[g] !== 1'b0 || rd[g] !== 32'd0 || er[g] !== 1'b0 || rdy[g] !== want_rdy) begin
        bad++;
        $display("FAIL %s inst=%0d got v=%b d=%h e=%b rdy=%b want v=0 d=0 e=0 rdy=%b",
                 tag, g, rv[g], rd[g], er[g], rdy[g], want_rdy);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset_state", 1'b0);
    reset = 1'b0;
    #1;
    check_quiet("ready_after_reset", 1'b1);
  endtask

  task automatic test_fill();
    for (int w = 0; w < 256; w++) do_req(1'b1, 3'd2, 32'(w * 4), $urandom);
  endtask

  task automatic test_directed();
    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    do_req(1'b0, 3'd2, 32'h10, 32'h0);
    do_req(1'b1, 3'd2, 32'h10, 32'h11223344);
    do_req(1'b1, 3'd0, 32'h13, 32'h00000080);
    do_req(1'b0, 3'd2, 32'h10, 32'h0);
    do_req(1'b0, 3'd0, 32'h13, 32'h0);
    do_req(1'b0, 3'd4, 32'h13, 32'h0);
    do_req(1'b1, 3'd2, 32'h20, 32'h55667788);
    do_req(1'b1, 3'd1, 32'h21, 32'h0000ABCD);
    do_req(1'b0, 3'd2, 32'h22, 32'h0);
    do_req(1'b0, 3'd3, 32'h20, 32'h0);
    do_req(1'b0, 3'd2, 32'h20, 32'h0);
    do_req(1'b0, 3'd2, 32'h400, 32'h0);
    do_req(1'b0, 3'd2, 32'h3FC, 32'h0);
    do_req(1'b1, 3'd2, 32'h04, 32'h80011234);
    do_req(1'b0, 3'd1, 32'h06, 32'h0);
    do_req(1'b0, 3'd5, 32'h06, 32'h0);
    do_req(1'b1, 3'd6, 32'h08, 32'hFFFFFFFF);
    do_req(1'b0, 3'd2, 32'h08, 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(7) == 0) a = $urandom | 32'h400;
      else                        a = $urandom_range(1023);
      do_req(1'($urandom_range(1)), 3'($urandom_range(7)), a, $urandom);
    end
  endtask

  // Second store is held during the first one's response and must wait for IDLE.
  task automatic test_back_to_back();
    logic e, ld;
    logic [31:0] r, va, vb;
    va = $urandom; vb = $urandom;
    model(1'b1, 3'd2, 32'h40, va, e, r, ld);
    model(1'b1, 3'd2, 32'h44, vb, e, r, ld);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = va;
    @(posedge clk); #1;
    req_addr = 32'h44; req_wdata = vb;
    for (int g = 0; g < NI; g++) begin
      total++;
      if (rv[g] !== 1'b1 || rdy[g] !== 1'b0 || er[g] !== 1'b0) begin
        bad++;
        $display("FAIL b2b_resp1 inst=%0d got v=%b rdy=%b e=%b want v=1 rdy=0 e=0", g, rv[g], rdy[g], er[g]);
      end
    end
    @(posedge clk); #1;
    check_quiet("b2b_idle_gap", 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int g = 0; g < NI; g++) begin
      total++;
      if (rv[g] !== 1'b1 || rdy[g] !== 1'b0) begin
        bad++;
        $display("FAIL b2b_resp2 inst=%0d got v=%b rdy=%b want v=1 rdy=0", g, rv[g], rdy[g]);
      end
    end
    @(posedge clk); #1;
    check_quiet("b2b_done", 1'b1);
    do_req(1'b0, 3'd2, 32'h40, 32'h0);
    do_req(1'b0, 3'd2, 32'h44, 32'h0);
  endtask

  task automatic test_reset_midop();
    do_req(1'b1, 3'd2, 32'h80, $urandom);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h80;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_quiet("reset_midop_during", 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
      check_quiet("reset_midop_held", 1'b0);
    end
    reset = 1'b0;
    #1;
    check_quiet("reset_midop_release", 1'b1);
    repeat (6) begin
      @(posedge clk); #1;
      check_quiet("reset_midop_no_pulse", 1'b1);
    end
    do_req(1'b0, 3'd2, 32'h80, 32'h0);
  endtask

  task automatic test_reset_same_cycle();
    reset = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h84; req_wdata = ~$urandom;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_quiet("reset_same_cycle", 1'b1);
    @(posedge clk); #1;
    check_quiet("reset_same_cycle_after", 1'b1);
    do_req(1'b0, 3'd2, 32'h84, 32'h0);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midop();
    test_reset_same_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_memory_be.md
DATA_MEMORY_BE -- requirements
Module: data_memory_be

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL be word-index width; depth = 2**ADDR_W 32-bit words (default 256 words, 1 KiB).
REQ-002 Parameter RD_LAT, default 1, legal 1..4, SHALL be cycles from read acceptance to rsp_valid.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block accepts request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  RISC-V funct3 size/sign code.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, LSB-aligned.
REQ-011 rsp_valid  output  1  one-cycle response pulse.
REQ-012 rsp_rdata  output  32  load result, extended to 32 bits.
REQ-013 rsp_err  output  1  request faulted; qualified by rsp_valid.

Function
REQ-014 Request SHALL be accepted when req_valid and req_ready are both 1 on a rising edge; one outstanding request maximum.
REQ-015 FSM states SHALL be IDLE, BUSY, RESP; req_ready = 1 only in IDLE.
REQ-016 IDLE->BUSY on accepted load with no fault; BUSY counts RD_LAT-1 further cycles, then ->RESP (RD_LAT=1: IDLE->RESP directly).
REQ-017 Accepted store or faulting request SHALL go IDLE->RESP; RESP->IDLE unconditionally after one cycle.
REQ-018 rsp_valid SHALL be 1 exactly in RESP; rsp_rdata and rsp_err SHALL hold their values only while rsp_valid = 1, else 0.
REQ-019 Load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-020 Store funct3: 000 SB, 001 SH, 010 SW; only selected bytes written (byte enables from addr[1:0]), other bytes preserved.
REQ-021 Store SHALL write memory on the acceptance edge; store response has rsp_rdata = 0.
REQ-022 Load data SHALL be captured from memory at acceptance; load latency = RD_LAT cycles from acceptance edge to rsp_valid.
REQ-023 Fault (rsp_err = 1, rsp_rdata = 0, no memory write) SHALL occur for: halfword with addr[0] = 1; word with addr[1:0] != 0; undefined funct3 (loads 011/110/111, stores 011..111); addr[31:ADDR_W+2] != 0.
REQ-024 Word index SHALL be addr[ADDR_W+1:2]; no wrap-around on out-of-range addresses (fault instead).
REQ-025 req_valid while req_ready = 0 SHALL be ignored; requester holds request until accepted.
REQ-026 Byte lane selection: byte at addr[1:0]=k is memory bits [8k+7:8k]; halfword at addr[1]=h is bits [16h+15:16h].

Reset
REQ-027 While reset = 1: FSM = IDLE, latency counter = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, req_ready = 0.
REQ-028 req_ready SHALL be 1 the first cycle after reset deasserts.
REQ-029 Reset mid-operation SHALL drop the in-flight request with no response; completed stores remain in memory.
REQ-030 Memory array contents SHALL NOT be cleared by reset.
REQ-031 Request presented in the same cycle as reset = 1 SHALL NOT be accepted or written.

Verification
REQ-032 SW 0xDEADBEEF @0x10, then LW @0x10, RD_LAT=1 -> store rsp_err=0; load rsp_valid 1 cycle after acceptance, rsp_rdata=0xDEADBEEF.
REQ-033 SB 0x80 @0x13 over word 0x11223344, then LB @0x13 and LBU @0x13 -> word becomes 0x80223344; LB=0xFFFFFF80, LBU=0x00000080.
REQ-034 SH 0xABCD @0x21, LW @0x22, funct3=011 load -> all rsp_err=1, rsp_rdata=0, word @0x20 unchanged.
REQ-035 ADDR_W=8, LW @0x400 -> rsp_err=1, no access; LW @0x3FC -> rsp_err=0.
REQ-036 RD_LAT=3, LH @0x06 on word 0x8001xxxx with back-to-back req_valid -> rsp_valid exactly 3 cycles after acceptance, rsp_rdata=0xFFFF8001, req_ready=0 during BUSY/RESP.
REQ-037 Assert reset while BUSY (RD_LAT=4) -> no rsp_valid pulse; req_ready=1 cycle after reset release; prior stored data still readable.
